// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and sizes for the LED matrix scan controller
package matrix_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef logic [COLS-1:0] row_t;
  typedef logic            color_t;

  typedef enum logic [1:0] {ST_SHIFT, ST_LATCH, ST_DISPLAY} scan_state_t;
endpackage

// File: rtl/matrix_tick_gen.sv
// rtl/matrix_tick_gen.sv - divides clk down to a one-cycle scan tick every CLK_DIV cycles
module matrix_tick_gen #(
  parameter int CLK_DIV = 1350
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  // Free-running divider; the tick cycle is the last count of each period.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Divider register, restarts from zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/matrix_scan_ctrl.sv
// rtl/matrix_scan_ctrl.sv - double-buffered 8x8 bicolour matrix scan sequencer
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int CLK_DIV    = 1350,
  parameter int HOLD_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_color,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  input  logic       blank,
  output logic       frame_start,
  output logic       mat_ser,
  output logic       col_red,
  output logic       col_green,
  output logic       mat_clock,
  output logic       mat_rclock,
  output logic       mat_clr_n
);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  logic tick;

  matrix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  scan_state_t   state_q, state_d;
  logic [3:0]    slot_q, slot_d;
  logic [2:0]    bit_q, bit_d;
  logic          phase_q, phase_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          front_q, front_d;
  logic          pend_q, pend_d;
  row_t          fb_q [2][2][ROWS];
  row_t          fb_d [2][2][ROWS];
  logic          ser_q, ser_d;
  logic          col_red_q, col_red_d;
  logic          col_green_q, col_green_d;
  logic          mclk_q, mclk_d;
  logic          rclk_q, rclk_d;
  logic          clr_n_q, clr_n_d;
  logic          ack_q, ack_d;
  logic          fs_q, fs_d;
  logic          swap_take;

  // Slot number is {row, colour}: red then green for each row.
  logic [2:0] cur_row;
  color_t     cur_color;
  logic       back_sel;
  assign cur_row   = slot_q[3:1];
  assign cur_color = slot_q[0];
  assign back_sel  = ~front_q;

  // Scan sequencing, swap handshake and back-buffer writes.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    front_d     = front_q;
    pend_d      = pend_q;
    fb_d        = fb_q;
    ser_d       = ser_q;
    col_red_d   = col_red_q;
    col_green_d = col_green_q;
    mclk_d      = mclk_q;
    rclk_d      = rclk_q;
    clr_n_d     = 1'b1;
    ack_d       = 1'b0;
    fs_d        = 1'b0;
    swap_take   = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_SHIFT: begin
          if (!phase_q) begin
            mclk_d      = 1'b0;
            ser_d       = fb_q[front_q][cur_color][cur_row][bit_q];
            col_red_d   = ~(bit_q == cur_row && cur_color == 1'b0 && !blank);
            col_green_d = ~(bit_q == cur_row && cur_color == 1'b1 && !blank);
            fs_d        = (slot_q == 4'd0) && (bit_q == 3'd0);
            phase_d     = 1'b1;
          end else begin
            mclk_d  = 1'b1;
            phase_d = 1'b0;
            if (bit_q == 3'd7) begin
              bit_d   = 3'd0;
              state_d = ST_LATCH;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        ST_LATCH: begin
          mclk_d  = 1'b0;
          rclk_d  = 1'b1;
          hold_d  = '0;
          state_d = ST_DISPLAY;
        end
        ST_DISPLAY: begin
          rclk_d = 1'b0;
          if (hold_q == HW'(HOLD_TICKS - 1)) begin
            slot_d    = slot_q + 4'd1;
            state_d   = ST_SHIFT;
            swap_take = (slot_q == 4'd15) && pend_q;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: state_d = ST_SHIFT;
      endcase
    end

    // A request arriving on the swap cycle itself stays pending for the next frame.
    if (swap_take) begin
      front_d = ~front_q;
      ack_d   = 1'b1;
      pend_d  = swap_req;
    end else if (swap_req) begin
      pend_d = 1'b1;
    end

    // Back buffer is chosen from the pre-swap front, so a write on the swap cycle becomes visible.
    if (wr_en) fb_d[back_sel][wr_color][wr_row] = wr_data;
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SHIFT;
      slot_q      <= 4'd0;
      bit_q       <= 3'd0;
      phase_q     <= 1'b0;
      hold_q      <= '0;
      front_q     <= 1'b0;
      pend_q      <= 1'b0;
      fb_q        <= '{default: '0};
      ser_q       <= 1'b0;
      col_red_q   <= 1'b1;
      col_green_q <= 1'b1;
      mclk_q      <= 1'b0;
      rclk_q      <= 1'b0;
      clr_n_q     <= 1'b0;
      ack_q       <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      front_q     <= front_d;
      pend_q      <= pend_d;
      fb_q        <= fb_d;
      ser_q       <= ser_d;
      col_red_q   <= col_red_d;
      col_green_q <= col_green_d;
      mclk_q      <= mclk_d;
      rclk_q      <= rclk_d;
      clr_n_q     <= clr_n_d;
      ack_q       <= ack_d;
      fs_q        <= fs_d;
    end
  end

  assign mat_ser     = ser_q;
  assign col_red     = col_red_q;
  assign col_green   = col_green_q;
  assign mat_clock   = mclk_q;
  assign mat_rclock  = rclk_q;
  assign mat_clr_n   = clr_n_q;
  assign swap_ack    = ack_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb/tb_matrix_scan_ctrl.sv - self-checking bench for matrix_scan_ctrl
module tb_matrix_scan_ctrl;
  localparam int CD = 2;
  localparam int HT = 2;
  localparam int ST = 17 + HT;
  localparam int FR = 16 * ST * CD;
  localparam logic [7:0] RST_OUTS = 8'b0110_0000;

  logic clk = 1'b0;
  logic rst_n, wr_en, wr_color, swap_req, blank;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic swap_ack, frame_start, mat_ser, col_red, col_green, mat_clock, mat_rclock, mat_clr_n;

  matrix_scan_ctrl #(.CLK_DIV(CD), .HOLD_TICKS(HT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_color(wr_color), .wr_row(wr_row),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack), .blank(blank),
    .frame_start(frame_start), .mat_ser(mat_ser), .col_red(col_red), .col_green(col_green),
    .mat_clock(mat_clock), .mat_rclock(mat_rclock), .mat_clr_n(mat_clr_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] outs;
  assign outs = {mat_ser, col_red, col_green, mat_clock, mat_rclock, mat_clr_n, swap_ack, frame_start};

  // Reference model: tick-number arithmetic over the frame, buffers as plain arrays.
  logic [7:0] m_fb [2][2][8];
  logic m_front, m_pend;
  int m_ec, m_tn;
  logic e_ser, e_cr, e_cg, e_clk, e_rclk, e_clr, e_ack, e_fs;

  function automatic void model_reset();
    for (int a = 0; a < 2; a++) for (int c = 0; c < 2; c++) for (int r = 0; r < 8; r++) m_fb[a][c][r] = 8'h00;
    m_front = 1'b0; m_pend = 1'b0; m_ec = 0; m_tn = 0;
    {e_ser, e_cr, e_cg, e_clk, e_rclk, e_clr, e_ack, e_fs} = RST_OUTS;
  endfunction

  function automatic bit swap_next();
    return ((m_ec % CD) == CD - 1) && (((m_tn / ST) % 16) == 15) && ((m_tn % ST) == ST - 1) && m_pend;
  endfunction

  function automatic void model_step();
    int slot, p, row, col, b;
    bit sw;
    logic bk;
    bk = ~m_front;
    sw = 1'b0;
    e_clr = 1'b1; e_ack = 1'b0; e_fs = 1'b0;
    if ((m_ec % CD) == CD - 1) begin
      slot = (m_tn / ST) % 16;
      p    = m_tn % ST;
      row  = slot / 2;
      col  = slot % 2;
      if (p < 16) begin
        b = p / 2;
        if (p % 2 == 0) begin
          e_clk = 1'b0;
          e_ser = m_fb[m_front][col][row][b];
          e_cr  = !(b == row && col == 0 && !blank);
          e_cg  = !(b == row && col == 1 && !blank);
          e_fs  = (slot == 0 && p == 0);
        end else begin
          e_clk = 1'b1;
        end
      end else if (p == 16) begin
        e_clk = 1'b0; e_rclk = 1'b1;
      end else begin
        e_rclk = 1'b0;
        sw = (p == ST - 1) && (slot == 15) && m_pend;
      end
      m_tn++;
    end
    if (sw) begin
      m_front = ~m_front; e_ack = 1'b1; m_pend = swap_req;
    end else if (swap_req) begin
      m_pend = 1'b1;
    end
    if (wr_en) m_fb[bk][wr_color][wr_row] = wr_data;
    m_ec++;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: model predicts, DUT steps, outputs compared 1 time unit after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("outs", 32'(outs), 32'({e_ser, e_cr, e_cg, e_clk, e_rclk, e_clr, e_ack, e_fs}));
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    while (!swap_ack && n < FR + 100) begin cyc(); n++; end
    check(nm, 32'(swap_ack), 32'd1);
  endtask

  task automatic wait_fs(input string nm);
    int n = 0;
    while (!frame_start && n < FR + 100) begin cyc(); n++; end
    check(nm, 32'(frame_start), 32'd1);
  endtask

  // Capture the 8 bits of a slot in the next frame, sampled at each rising mat_clock.
  task automatic cap_slot(input int slot, output logic [7:0] s, output logic [7:0] cr, output logic [7:0] cg);
    int rises = 0;
    int n = 0;
    logic prev;
    s = 8'h00; cr = 8'h00; cg = 8'h00;
    wait_fs("cap_frame_start");
    prev = mat_clock;
    while (rises < 8 * (slot + 1) && n < FR) begin
      cyc(); n++;
      if (mat_clock && !prev) begin
        if (rises >= 8 * slot) begin
          s[rises - 8 * slot] = mat_ser;
          cr[rises - 8 * slot] = col_red;
          cg[rises - 8 * slot] = col_green;
        end
        rises++;
      end
      prev = mat_clock;
    end
    check("cap_rises", 32'(rises), 32'(8 * (slot + 1)));
  endtask

  typedef struct {
    logic       color;
    logic [2:0] row;
    logic [7:0] data;
    logic       blk;
    logic [7:0] ser;
    logic [7:0] cr;
    logic [7:0] cg;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [7:0] s, cr, cg;
    int n, acks, lows, rises;
    logic prev;

    tbl[0] = '{1'b0, 3'd0, 8'hA5, 1'b0, 8'hA5, 8'hFE, 8'hFF};
    tbl[1] = '{1'b1, 3'd1, 8'h3C, 1'b0, 8'h3C, 8'hFF, 8'hFD};
    tbl[2] = '{1'b0, 3'd6, 8'hFF, 1'b1, 8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{1'b1, 3'd7, 8'h81, 1'b0, 8'h81, 8'hFF, 8'h7F};

    rst_n = 1'b0; wr_en = 1'b0; wr_color = 1'b0; wr_row = 3'd0; wr_data = 8'h00;
    swap_req = 1'b0; blank = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset_outs", 32'(outs), 32'(RST_OUTS));
    rst_n = 1'b1;
    cyc();
    check("clr_n_after_release", 32'(mat_clr_n), 32'd1);

    // Asynchronous reset in the middle of slot 5's shift.
    n = 0;
    while (m_tn < 5 * ST + 5 && n < 1000) begin cyc(); n++; end
    check("reached_slot5", 32'(m_tn >= 5 * ST + 5), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", 32'(outs), 32'(RST_OUTS));
    @(posedge clk); @(posedge clk); #1;
    check("reset_held_outs", 32'(outs), 32'(RST_OUTS));
    rst_n = 1'b1;
    model_reset();
    cyc();
    check("clr_n_one_clk", 32'(mat_clr_n), 32'd1);
    n = 1;
    while (!frame_start && n < 20) begin cyc(); n++; end
    check("first_fs_cycles", 32'(n), 32'(CD));

    // Table: write back buffer, swap, then read the slot back off the chains.
    for (int i = 0; i < 4; i++) begin
      blank = tbl[i].blk;
      wr_en = 1'b1; wr_color = tbl[i].color; wr_row = tbl[i].row; wr_data = tbl[i].data;
      cyc();
      wr_en = 1'b0; swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      wait_ack("tbl_swap_ack");
      cap_slot(int'(tbl[i].row) * 2 + int'(tbl[i].color), s, cr, cg);
      check("tbl_ser", 32'(s), 32'(tbl[i].ser));
      check("tbl_col_red", 32'(cr), 32'(tbl[i].cr));
      check("tbl_col_green", 32'(cg), 32'(tbl[i].cg));
      blank = 1'b0;
    end

    // Three requests in one frame give exactly one swap.
    wait_fs("multi_req_fs");
    acks = 0;
    for (int k = 0; k < 2 * FR; k++) begin
      swap_req = (k == 10 || k == 100 || k == 300);
      cyc();
      if (swap_ack) acks++;
    end
    swap_req = 1'b0;
    check("multi_req_acks", 32'(acks), 32'd1);

    // Write and a fresh request on the swap cycle itself.
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    n = 0;
    while (!swap_next() && n < FR + 100) begin cyc(); n++; end
    check("swap_edge_found", 32'(swap_next()), 32'd1);
    wr_en = 1'b1; wr_color = 1'b1; wr_row = 3'd7; wr_data = 8'h5A; swap_req = 1'b1;
    cyc();
    wr_en = 1'b0; swap_req = 1'b0;
    check("swap_wr_ack", 32'(swap_ack), 32'd1);
    cap_slot(15, s, cr, cg);
    check("swap_wr_ser", 32'(s), 32'h5A);
    check("swap_wr_col_green", 32'(cg), 32'h7F);
    check("swap_wr_col_red", 32'(cr), 32'hFF);
    wait_ack("pending_after_swap_req");

    // Blank for a whole frame: column lines dark, shift clock still running.
    blank = 1'b1;
    wait_fs("blank_fs");
    lows = 0; rises = 0; prev = mat_clock;
    for (int k = 0; k < FR; k++) begin
      if (!col_red || !col_green) lows++;
      if (mat_clock && !prev) rises++;
      prev = mat_clock;
      cyc();
    end
    blank = 1'b0;
    check("blank_col_lows", 32'(lows), 32'd0);
    check("blank_clock_rises", 32'(rises), 32'd128);

    // Frame period.
    wait_fs("period_fs0");
    n = 0;
    do begin cyc(); n++; end while (!frame_start && n < FR + 100);
    check("frame_period", 32'(n), 32'(FR));

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_color = 1'($urandom_range(0, 1));
      wr_row   = 3'($urandom_range(0, 7));
      wr_data  = 8'($urandom_range(0, 255));
      swap_req = ($urandom_range(0, 150) == 0);
      if (k % 64 == 0) blank = ($urandom_range(0, 3) == 0);
      cyc();
    end
    wr_en = 1'b0; swap_req = 1'b0; blank = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
